// File: rtl/gemm_tile_scheduler.sv
// rtl/gemm_tile_scheduler.sv - tile sequencer between the control front end and the loader/systolic array
//
// Purpose: walks a job of tile_count tiles through configure -> wait for
// weights -> send weights -> compute, overlapping the next tile's weight
// fetch (grant) with the current tile's compute.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         job start / cancel pulses from the front end
//   tile_count           tiles in the job, sampled on an accepted start
//   busy, done           job status and completion pulse
//   tile_idx             tile currently being sent/computed
//   cfg_init             loader configuration pulse
//   weight_load_req      loader asks to fetch the next tile
//   weight_load_grant    permission pulse for that fetch
//   weight_data_valid    loader buffer holds a full tile
//   send_weight_trigger  pulse that pushes the buffered tile into the array
//   weight_sending_done  loader has finished pushing weights
//   compute_start        pulse that starts array compute
//   compute_done         array compute finished pulse

module gemm_tile_scheduler #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REG_WIDTH-1:0] tile_count,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] tile_idx,
  output logic                 cfg_init,
  input  logic                 weight_load_req,
  output logic                 weight_load_grant,
  input  logic                 weight_data_valid,
  output logic                 send_weight_trigger,
  input  logic                 weight_sending_done,
  output logic                 compute_start,
  input  logic                 compute_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_DATA,
    S_SEND,
    S_COMPUTE,
    S_FINISH
  } state_t;

  state_t               r_state;
  logic [REG_WIDTH-1:0] r_cnt_total;
  logic                 r_comp_seen;
  logic                 r_grant_seen;

  logic                 w_last;
  logic                 w_grant_ok;

  // The last tile has no successor to fetch, so its grant counts as already given.
  assign w_last     = (tile_idx == (r_cnt_total - {{(REG_WIDTH-1){1'b0}}, 1'b1}));
  assign w_grant_ok = r_grant_seen | w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= S_IDLE;
      r_cnt_total         <= '0;
      r_comp_seen         <= 1'b0;
      r_grant_seen        <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      tile_idx            <= '0;
      cfg_init            <= 1'b0;
      weight_load_grant   <= 1'b0;
      send_weight_trigger <= 1'b0;
      compute_start       <= 1'b0;
    end else begin
      // Pulse outputs are raised on the edge that enters the state they
      // belong to, so they line up with the first cycle of that state.
      done                <= 1'b0;
      cfg_init            <= 1'b0;
      weight_load_grant   <= 1'b0;
      send_weight_trigger <= 1'b0;
      compute_start       <= 1'b0;

      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_cnt_total <= tile_count;
              tile_idx    <= '0;
              busy        <= 1'b1;
              if (tile_count == '0) begin
                r_state <= S_FINISH;
                done    <= 1'b1;
              end else begin
                r_state  <= S_INIT;
                cfg_init <= 1'b1;
              end
            end
          end
          S_INIT: begin
            // Loader self-starts tile 0; no grant needed here.
            r_state <= S_WAIT_DATA;
          end
          S_WAIT_DATA: begin
            if (weight_data_valid) begin
              r_state             <= S_SEND;
              send_weight_trigger <= 1'b1;
            end
          end
          S_SEND: begin
            if (weight_sending_done) begin
              r_state       <= S_COMPUTE;
              compute_start <= 1'b1;
              r_comp_seen   <= 1'b0;
              r_grant_seen  <= 1'b0;
            end
          end
          S_COMPUTE: begin
            // Advance uses the registered flags, so it happens no earlier
            // than the edge that ends the grant cycle.
            if (r_comp_seen && w_grant_ok) begin
              if (w_last) begin
                r_state <= S_FINISH;
                done    <= 1'b1;
              end else begin
                tile_idx <= tile_idx + {{(REG_WIDTH-1){1'b0}}, 1'b1};
                r_state  <= S_WAIT_DATA;
              end
            end else begin
              if (compute_done) begin
                r_comp_seen <= 1'b1;
              end
              if (!w_grant_ok && weight_load_req) begin
                weight_load_grant <= 1'b1;
                r_grant_seen      <= 1'b1;
              end
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// tb/tb_gemm_tile_scheduler.sv - directed self-checking bench for gemm_tile_scheduler

module tb_gemm_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] tile_count;
  logic        busy;
  logic        done;
  logic [31:0] tile_idx;
  logic        cfg_init;
  logic        weight_load_req;
  logic        weight_load_grant;
  logic        weight_data_valid;
  logic        send_weight_trigger;
  logic        weight_sending_done;
  logic        compute_start;
  logic        compute_done;

  int n_tests = 0;
  int n_fail  = 0;

  int n_cfg = 0, n_trig = 0, n_cs = 0, n_grant = 0, n_done = 0;
  int b_cfg, b_trig, b_cs, b_grant, b_done;
  int idx_log [64];

  gemm_tile_scheduler #(.REG_WIDTH(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .abort               (abort),
    .tile_count          (tile_count),
    .busy                (busy),
    .done                (done),
    .tile_idx            (tile_idx),
    .cfg_init            (cfg_init),
    .weight_load_req     (weight_load_req),
    .weight_load_grant   (weight_load_grant),
    .weight_data_valid   (weight_data_valid),
    .send_weight_trigger (send_weight_trigger),
    .weight_sending_done (weight_sending_done),
    .compute_start       (compute_start),
    .compute_done        (compute_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_init)            n_cfg   <= n_cfg + 1;
    if (send_weight_trigger) n_trig  <= n_trig + 1;
    if (weight_load_grant)   n_grant <= n_grant + 1;
    if (done)                n_done  <= n_done + 1;
    if (compute_start) begin
      if (n_cs < 64) idx_log[n_cs] <= int'(tile_idx);
      n_cs <= n_cs + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_out(input int sel);
    return (sel == 0) ? send_weight_trigger : compute_start;
  endfunction

  task automatic wait_out(input int sel, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (get_out(sel) === 1'b1) return;
      step();
    end
    check(32'd0, 32'd1, {tag, " timeout"});
  endtask

  task automatic snap();
    b_cfg = n_cfg; b_trig = n_trig; b_cs = n_cs; b_grant = n_grant; b_done = n_done;
  endtask

  task automatic expect_counts(input int c, input int tr, input int cs, input int g, input int d,
                               input string tag);
    check(n_cfg - b_cfg,     c,  {tag, " cfg_init count"});
    check(n_trig - b_trig,   tr, {tag, " send_trigger count"});
    check(n_cs - b_cs,       cs, {tag, " compute_start count"});
    check(n_grant - b_grant, g,  {tag, " grant count"});
    check(n_done - b_done,   d,  {tag, " done count"});
  endtask

  // Drives a job with a reactive loader/array model. req_dly / cd_dly are
  // cycles after compute_start at which weight_load_req / compute_done pulse.
  task automatic run_job(input int cnt, input int req_dly, input int cd_dly, input int abort_t,
                         input bit spur, input string tag);
    int m;
    bit last;
    bit stop;
    tile_count = cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    check(busy, 1, {tag, " busy after start"});
    if (cnt == 0) begin
      check(done, 1, {tag, " done T+1"});
      check(cfg_init, 0, {tag, " no cfg_init"});
      step();
      check(done, 0, {tag, " done one cycle"});
      check(busy, 0, {tag, " busy cleared"});
      return;
    end
    check(cfg_init, 1, {tag, " cfg_init T+1"});
    stop = 1'b0;
    for (int t = 0; t < cnt && !stop; t++) begin
      last = (t == cnt - 1);
      weight_data_valid = 1'b1;
      if (spur) begin
        compute_done    = 1'b1;
        weight_load_req = 1'b1;
      end
      step();
      compute_done    = 1'b0;
      weight_load_req = 1'b0;
      wait_out(0, {tag, " send_trigger"});
      weight_data_valid = 1'b0;
      check(tile_idx, t, {tag, " tile_idx at send"});
      if (t == abort_t) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check(busy, 0, {tag, " busy after abort"});
        check(send_weight_trigger, 0, {tag, " trig after abort"});
        check(compute_start, 0, {tag, " cs after abort"});
        repeat (3) step();
        stop = 1'b1;
      end else begin
        weight_sending_done = 1'b1;
        wait_out(1, {tag, " compute_start"});
        weight_sending_done = 1'b0;
        m = last ? cd_dly : ((req_dly > cd_dly) ? req_dly : cd_dly);
        for (int k = 0; k <= m + 1; k++) begin
          check(tile_idx, t, {tag, " tile_idx hold in compute"});
          check(weight_load_grant, (!last && k == req_dly + 1) ? 1 : 0, {tag, " grant timing"});
          if (spur && k == 0) begin
            start               = 1'b1;
            tile_count          = 9;
            weight_sending_done = 1'b1;
          end
          weight_load_req = (!last && k == req_dly);
          compute_done    = (k == cd_dly);
          step();
          start               = 1'b0;
          weight_sending_done = 1'b0;
          weight_load_req     = 1'b0;
          compute_done        = 1'b0;
        end
        tile_count = cnt;
        if (last) begin
          check(done, 1, {tag, " done pulse"});
          check(busy, 1, {tag, " busy in finish"});
          step();
          check(done, 0, {tag, " done one cycle"});
          check(busy, 0, {tag, " busy after job"});
        end else begin
          check(tile_idx, t + 1, {tag, " tile_idx advance"});
          check(busy, 1, {tag, " busy mid job"});
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; tile_count = '0;
    weight_load_req = 1'b0; weight_data_valid = 1'b0;
    weight_sending_done = 1'b0; compute_done = 1'b0;
    step();
    step();
    check(busy, 0, "reset busy");
    check(done, 0, "reset done");
    check(tile_idx, 0, "reset tile_idx");
    check(cfg_init, 0, "reset cfg_init");
    check(weight_load_grant, 0, "reset grant");
    check(send_weight_trigger, 0, "reset trig");
    check(compute_start, 0, "reset compute_start");
    rst_n = 1'b1;
    step();

    snap();
    run_job(1, 0, 0, -1, 1'b0, "t1");
    expect_counts(1, 1, 1, 0, 1, "t1");

    snap();
    run_job(4, 2, 4, -1, 1'b0, "t4");
    expect_counts(1, 4, 4, 3, 1, "t4");
    for (int i = 0; i < 4; i++) check(idx_log[b_cs + i], i, "t4 idx sequence");

    snap();
    run_job(3, 10, 1, -1, 1'b0, "t3late");
    expect_counts(1, 3, 3, 2, 1, "t3late");

    snap();
    run_job(0, 0, 0, -1, 1'b0, "t0");
    expect_counts(0, 0, 0, 0, 1, "t0");

    snap();
    run_job(5, 2, 3, 2, 1'b0, "abort");
    expect_counts(1, 3, 2, 2, 0, "abort");

    snap();
    run_job(2, 1, 1, -1, 1'b0, "restart");
    expect_counts(1, 2, 2, 1, 1, "restart");
    check(idx_log[b_cs], 0, "restart idx0");
    check(idx_log[b_cs + 1], 1, "restart idx1");

    // Stray pulses and abort while idle must not start anything.
    snap();
    compute_done = 1'b1; weight_sending_done = 1'b1; weight_load_req = 1'b1;
    weight_data_valid = 1'b1; abort = 1'b1;
    step();
    compute_done = 1'b0; weight_sending_done = 1'b0; weight_load_req = 1'b0;
    weight_data_valid = 1'b0; abort = 1'b0;
    step();
    check(busy, 0, "idle spurious busy");
    run_job(3, 1, 2, -1, 1'b1, "spur");
    expect_counts(1, 3, 3, 2, 1, "spur");

    // Asynchronous reset mid-job.
    tile_count = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    check(cfg_init, 1, "areset pre cfg_init");
    rst_n = 1'b0;
    #1;
    check(cfg_init, 0, "areset cfg_init");
    check(busy, 0, "areset busy");
    step();
    rst_n = 1'b1;
    step();
    check(busy, 0, "after areset idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_tile_scheduler.md
# gemm_tile_scheduler

Sequences tiled matrix-multiply execution around the weight loader and the systolic array. The block issues the loader's configuration strobe and grants each subsequent tile load. It triggers each weight send into the array, starts and tracks compute for every tile, and overlaps the next tile's weight fetch with the current tile's compute. It sits between the accelerator's register/control front end and the kernel loader / systolic array pair.

## Interface
Parameters:
- REG_WIDTH, 32, width of tile_count and tile_idx

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  single-cycle pulse; begin a job of tile_count tiles
- abort  in  1  single-cycle pulse; cancel current job
- tile_count  in  REG_WIDTH  number of tiles; sampled when start is accepted
- busy  out  1  job in progress
- done  out  1  single-cycle pulse; all tiles computed
- tile_idx  out  REG_WIDTH  index of tile currently being sent/computed
- cfg_init  out  1  single-cycle pulse to loader init_cfg
- weight_load_req  in  1  loader requests permission for next tile fetch
- weight_load_grant  out  1  single-cycle grant pulse to loader
- weight_data_valid  in  1  loader buffer holds a complete tile
- send_weight_trigger  out  1  single-cycle pulse to loader
- weight_sending_done  in  1  loader finished pushing weights into the array
- compute_start  out  1  single-cycle pulse to array control
- compute_done  in  1  single-cycle pulse from array control

## Operation
- States: IDLE, INIT, WAIT_DATA, SEND, COMPUTE, FINISH.
- IDLE: start=1 latches tile_count into cnt_total and clears tile_idx. If tile_count=0, go to FINISH. Otherwise go to INIT.
- INIT: cfg_init=1 for this one cycle; go to WAIT_DATA. The loader self-starts tile 0, so no grant is issued for tile 0.
- WAIT_DATA: when weight_data_valid=1, go to SEND.
- SEND: send_weight_trigger=1 on the first SEND cycle only. Wait for weight_sending_done=1, then go to COMPUTE.
- COMPUTE: compute_start=1 on the first COMPUTE cycle only. On entry, clear the sticky flags comp_seen and grant_seen.
  - grant_seen is forced to 1 when tile_idx = cnt_total-1 (last tile).
  - If grant_seen=0 and weight_load_req=1, pulse weight_load_grant for one cycle and set grant_seen.
  - compute_done=1 sets comp_seen.
  - When comp_seen and grant_seen are both set: on the last tile go to FINISH; otherwise increment tile_idx and go to WAIT_DATA.
- FINISH: done=1 for one cycle; go to IDLE.
- busy=1 in every state except IDLE.
- Ignored inputs:
  - start while busy.
  - weight_sending_done outside SEND.
  - compute_done outside COMPUTE.
  - weight_load_req outside COMPUTE, or after grant_seen.
- abort in any non-IDLE state: go to IDLE next cycle. No done pulse. All pulse outputs are 0 from that edge on. abort has priority over every other transition. abort in IDLE is a no-op.
- Total grants per job = tile_count-1. Exactly one send_weight_trigger and one compute_start per tile.
- tile_idx is compared against cnt_total-1 at full REG_WIDTH width. Valid range is 1..2^REG_WIDTH-1.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, tile_idx=0, cfg_init=0, weight_load_grant=0, send_weight_trigger=0, compute_start=0. State is IDLE.
- start accepted at edge T: cfg_init=1 during cycle T+1.
- weight_data_valid sampled 1 at edge T: send_weight_trigger=1 during cycle T+1.
- weight_sending_done sampled at edge T: compute_start=1 during cycle T+1.
- weight_load_req sampled at edge T in COMPUTE: weight_load_grant=1 during cycle T+1.
  - A request in the same cycle as compute_done is still granted.
  - The advance to WAIT_DATA occurs no earlier than the edge after the grant cycle.
- tile_count=0: done=1 during cycle T+1 after start; cfg_init is never asserted.
- Minimum per-tile overhead beyond loader/array latency: 3 cycles (WAIT_DATA→SEND→COMPUTE→advance).
- Reset asserted mid-job returns all outputs to reset values asynchronously.

## Test plan
- tile_count=1, immediate valid/sending_done/compute_done → exactly 1 cfg_init, 1 send_weight_trigger, 1 compute_start, 0 grants, done pulse; busy 1→0.
- tile_count=4, loader raises weight_load_req 2 cycles after each compute_start → 3 grants. tile_idx steps 0,1,2,3. 4 sends, 4 computes, one done.
- tile_count=3, compute_done arrives before weight_load_req (req delayed 10 cycles) → scheduler holds in COMPUTE. Grant issued the cycle after req; tile_idx advances only then.
- tile_count=0 → done exactly 1 cycle after start; no cfg_init or any other pulse; busy stays 0 except FINISH cycle.
- abort during SEND of tile 2 of 5 → IDLE next cycle, no done. A new start with tile_count=2 runs cleanly from tile_idx=0.
- start and spurious compute_done/weight_sending_done pulses injected in wrong states → ignored; pulse counts unchanged vs. clean run.
